// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display controller:
// FSM states, the active-low glyph table and the BCD digit-count helper.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Cathode patterns are active-low, ordered {a,b,c,d,e,f,g}.
  localparam logic [6:0] GLYPH_ZERO  = 7'b0000001;
  localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  function automatic int bcd_digits(input int data_w);
    return (data_w * 3) / 10 + 1;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0000100;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b1100000;
      4'hC:    glyph = 7'b0110001;
      4'hD:    glyph = 7'b1000010;
      4'hE:    glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift-add-3 step per cycle, DATA_W cycles
// per conversion. done marks the final step; bcd is valid from the following cycle.
module bin2bcd_seq
  import sevenseg_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int BCD_DIGITS = bcd_digits(DATA_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [BCD_W-1:0]  bcd_q, bcd_d, adj;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, otherwise a latch is inferred.
    adj    = bcd_q;
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    if (start) begin
      bcd_d  = '0;
      bin_d  = bin_in;
      cnt_d  = CNT_W'(DATA_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/sevenseg_scan_controller.sv
// N-digit multiplexed 7-segment driver: valid/ready value intake, BCD or hex
// conversion, leading-zero/overflow rendering and a blanked, registered digit scan.
module sevenseg_scan_controller
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DATA_W       = 16,
  parameter int REFRESH_DIV  = 262144,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic [NUM_DIGITS-1:0] anode_activate,
  output logic [6:0]            led_out,
  output logic                  dp_out,
  output logic                  overflow
);

  localparam int BCD_DIGITS = bcd_digits(DATA_W);
  localparam int HEX_DIGITS = (DATA_W + 3) / 4;
  localparam int SRC_DIGITS = (BCD_DIGITS > HEX_DIGITS) ? BCD_DIGITS : HEX_DIGITS;
  localparam int PAD_W      = 4 * (NUM_DIGITS + SRC_DIGITS);
  localparam int PRE_W      = $clog2(REFRESH_DIV);
  localparam int SLOT_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e state_q, state_d;
  logic   accept, commit, conv_start, conv_busy, conv_done;
  logic [4*BCD_DIGITS-1:0] bcd;

  logic [DATA_W-1:0] val_q, val_d;
  logic              hex_q, hex_d, blz_q, blz_d;

  logic [NUM_DIGITS-1:0][6:0] glyph_q, glyph_d, commit_glyph;
  logic                       ovf_q, ovf_d, commit_ovf;
  logic [PAD_W-1:0]           src_pad;
  logic [3:0]                 digit;
  logic                       seen_nz;

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [6:0]            cur_glyph_q, cur_glyph_d;
  logic                  wrap, blanking;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            led_q, led_d;
  logic                  dp_q, dp_d;

  bin2bcd_seq #(.DATA_W(DATA_W), .BCD_DIGITS(BCD_DIGITS)) u_bin2bcd (
    .clk    (clock_100Mhz),
    .rst_n  (reset),
    .start  (conv_start),
    .bin_in (value_in),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (bcd)
  );

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The !conv_busy term keeps CONV from stalling if the converter was never started.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (value_valid) state_d = hex_mode ? ST_COMMIT : ST_CONV;
      ST_CONV:   if (conv_done || !conv_busy) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    value_ready = (state_q == ST_IDLE);
    commit      = (state_q == ST_COMMIT);
    accept      = value_ready && value_valid;
    conv_start  = accept && !hex_mode;
  end

  always_comb begin
    val_d   = accept ? value_in : val_q;
    hex_d   = accept ? hex_mode : hex_q;
    blz_d   = accept ? blank_lz : blz_q;
    src_pad = hex_q ? PAD_W'(val_q) : PAD_W'(bcd);
    // Anything above the displayable digits means the value does not fit.
    commit_ovf   = |(src_pad >> (4 * NUM_DIGITS));
    commit_glyph = '1;
    digit        = '0;
    seen_nz      = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      digit = src_pad[4*i +: 4];
      if (digit != 4'd0) seen_nz = 1'b1;
      if (commit_ovf)                         commit_glyph[i] = GLYPH_DASH;
      else if (seen_nz || i == 0 || !blz_q)   commit_glyph[i] = glyph(digit);
      else                                    commit_glyph[i] = GLYPH_BLANK;
    end
    glyph_d = commit ? commit_glyph : glyph_q;
    ovf_d   = commit ? commit_ovf   : ovf_q;
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
      hex_q <= 1'b0;
      blz_q <= 1'b0;
      ovf_q <= 1'b0;
      // NOTE: the display register is a few flops, not a RAM, so it resets to a defined idle image.
      for (int i = 0; i < NUM_DIGITS; i++) glyph_q[i] <= (i == 0) ? GLYPH_ZERO : GLYPH_BLANK;
    end else begin
      val_q   <= val_d;
      hex_q   <= hex_d;
      blz_q   <= blz_d;
      ovf_q   <= ovf_d;
      glyph_q <= glyph_d;
    end
  end

  // The slot's glyph is captured only at slot start, so a commit never splits a slot.
  always_comb begin
    wrap        = (presc_q == PRE_W'(REFRESH_DIV - 1));
    presc_d     = wrap ? '0 : presc_q + 1'b1;
    slot_d      = slot_q;
    if (wrap) slot_d = (slot_q == '0) ? SLOT_W'(NUM_DIGITS - 1) : slot_q - 1'b1;
    cur_glyph_d = wrap ? glyph_d[slot_d] : cur_glyph_q;
    blanking    = (presc_q < PRE_W'(BLANK_CYCLES));
    anode_d     = '1;
    if (!blanking) anode_d[slot_q] = 1'b0;
    led_d       = blanking ? GLYPH_BLANK : cur_glyph_q;
    dp_d        = blanking ? 1'b1 : ~dp_in[slot_q];
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      presc_q     <= '0;
      slot_q      <= SLOT_W'(NUM_DIGITS - 1);
      cur_glyph_q <= (NUM_DIGITS == 1) ? GLYPH_ZERO : GLYPH_BLANK;
      anode_q     <= '1;
      led_q       <= GLYPH_BLANK;
      dp_q        <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      slot_q      <= slot_d;
      cur_glyph_q <= cur_glyph_d;
      anode_q     <= anode_d;
      led_q       <= led_d;
      dp_q        <= dp_d;
    end
  end

  assign anode_activate = anode_q;
  assign led_out        = led_q;
  assign dp_out         = dp_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_sevenseg_scan_controller.sv
// Scoreboard bench for sevenseg_scan_controller: stimulus pushes expected displays,
// a monitor pops them at each commit/reset release and checks a full scan frame.
module tb_sevenseg_scan_controller;

  localparam int ND = 4;
  localparam int DW = 16;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] value_in = '0;
  logic          value_valid = 1'b0;
  logic          value_ready;
  logic          hex_mode = 1'b0;
  logic          blank_lz = 1'b0;
  logic [ND-1:0] dp_in = '0;
  logic [ND-1:0] anode_activate;
  logic [6:0]    led_out;
  logic          dp_out;
  logic          overflow;

  sevenseg_scan_controller #(
    .NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
  ) dut (
    .clock_100Mhz   (clk),
    .reset          (rst_n),
    .value_in       (value_in),
    .value_valid    (value_valid),
    .value_ready    (value_ready),
    .hex_mode       (hex_mode),
    .blank_lz       (blank_lz),
    .dp_in          (dp_in),
    .anode_activate (anode_activate),
    .led_out        (led_out),
    .dp_out         (dp_out),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef enum {EV_COMMIT, EV_RESET} ev_e;
  typedef struct {
    ev_e                 kind;
    logic [ND-1:0][6:0]  glyph;
    logic                ovf;
    int                  lat;
    bit                  frame;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int frames_issued = 0;
  int frames_done = 0;
  int cyc = 0;

  // Clock edges since reset release; the scan position is derived from this alone.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic exp_t model(input int unsigned v, input bit hex, input bit blz);
    exp_t e;
    int unsigned base;
    int unsigned d [ND];
    longint unsigned p;
    int msd;
    base = hex ? 16 : 10;
    p = 1;
    msd = 0;
    for (int i = 0; i < ND; i++) begin
      d[i] = int'((longint'(v) / p) % base);
      p = p * base;
    end
    e.kind = EV_COMMIT;
    e.ovf = (longint'(v) >= p);
    for (int i = 0; i < ND; i++) if (d[i] != 0) msd = i;
    for (int i = 0; i < ND; i++) begin
      if (e.ovf)                 e.glyph[i] = SEG_DASH;
      else if (blz && i > msd)   e.glyph[i] = SEG_BLANK;
      else                       e.glyph[i] = SEG_TAB[d[i]];
    end
    e.lat = hex ? 1 : DW + 1;
    e.frame = 1'b0;
    return e;
  endfunction

  function automatic exp_t reset_model();
    exp_t e;
    e = model(0, 1'b0, 1'b1);
    e.kind = EV_RESET;
    e.frame = 1'b1;
    return e;
  endfunction

  // Checks one full scan frame starting at the first slot boundary after now.
  task automatic check_frame(input exp_t e);
    int guard;
    int pos, off, didx;
    bit blank;
    logic [ND-1:0] exp_an;
    logic [6:0] exp_led, act_led;
    logic exp_dp;
    guard = 0;
    @(negedge clk);
    while ((cyc == 0 || ((cyc - 1) % RD) != 0) && guard < 4 * RD) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 4 * RD) flag("slot_start_timeout");
    for (int k = 0; k < FRAME; k++) begin
      pos   = ((cyc - 1) / RD) % ND;
      off   = (cyc - 1) % RD;
      didx  = ND - 1 - pos;
      blank = (off < BC);
      exp_an = '1;
      if (!blank) exp_an[didx] = 1'b0;
      exp_dp  = blank ? 1'b1 : ~dp_in[didx];
      exp_led = blank ? SEG_BLANK : e.glyph[didx];
      act_led = blank ? SEG_BLANK : led_out;
      check($sformatf("scan pos%0d off%0d {anode,led,dp}", pos, off),
            {20'd0, anode_activate, act_led, dp_out}, {20'd0, exp_an, exp_led, exp_dp});
      if (k != FRAME - 1) @(negedge clk);
    end
    frames_done++;
  endtask

  initial begin : monitor
    bit prev_rdy;
    bit in_reset;
    int low_cnt;
    exp_t e;
    prev_rdy = 1'b1;
    in_reset = 1'b0;
    low_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_reset = 1'b1;
        low_cnt = 0;
        continue;
      end
      if (in_reset) begin
        in_reset = 1'b0;
        if (sb.size() > 0 && sb[0].kind == EV_RESET) begin
          e = sb.pop_front();
          check("ready_after_reset", {31'd0, value_ready}, 32'd1);
          check("overflow_after_reset", {31'd0, overflow}, {31'd0, e.ovf});
          check_frame(e);
        end else begin
          flag("unexpected_reset");
        end
        prev_rdy = value_ready;
        continue;
      end
      if (!value_ready) begin
        low_cnt++;
      end else if (!prev_rdy) begin
        if (sb.size() == 0 || sb[0].kind != EV_COMMIT) begin
          flag("unexpected_commit");
        end else begin
          e = sb.pop_front();
          check("ready_low_cycles", low_cnt, e.lat);
          check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
          if (e.frame) check_frame(e);
        end
        low_cnt = 0;
      end
      prev_rdy = value_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input int cycles);
    sb.push_back(reset_model());
    frames_issued++;
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input int unsigned v, input bit hex, input bit blz,
                      input bit expect_commit, input bit frame, input bit hold);
    bit accepted, rdy;
    exp_t e;
    value_in = DW'(v);
    hex_mode = hex;
    blank_lz = blz;
    value_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 100 && !accepted; k++) begin
      @(negedge clk);
      rdy = value_ready;
      tick();
      if (rdy) accepted = 1'b1;
    end
    if (!accepted) begin
      flag($sformatf("transfer_timeout value=%0d", v));
    end else if (expect_commit) begin
      e = model(v, hex, blz);
      e.frame = frame;
      sb.push_back(e);
      if (frame) frames_issued++;
    end
    if (!hold) value_valid = 1'b0;
  endtask

  task automatic wait_frames();
    for (int k = 0; k < 2000 && frames_done < frames_issued; k++) tick();
    if (frames_done < frames_issued) flag("frame_wait_timeout");
  endtask

  initial begin : stimulus
    int unsigned v;
    #1;
    // Idle display after reset: blanks with a single 0 on the right.
    reset_pulse(3);
    wait_frames();

    dp_in = 4'b0000;
    send(1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_frames();
    send(42, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_frames();
    send(42, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_frames();
    dp_in = 4'b1001;
    send(12345, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_frames();
    send(16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_frames();
    send(16'h00A0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_frames();

    // Reset in the middle of a conversion discards it.
    send(9999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    reset_pulse(1);
    wait_frames();

    // Valid held high across three back-to-back values.
    dp_in = 4'b0100;
    send(7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_frames();

    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 2))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 9999);
        default: v = $urandom_range(0, 65535);
      endcase
      dp_in = ND'($urandom);
      send(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
      wait_frames();
    end

    for (int k = 0; k < 200 && sb.size() > 0; k++) tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
